// File: rtl/startscreen_drawer.sv
// Copies the start-screen ROM image into the VGA framebuffer, one pixel per clock,
// in raster order. The x/y/plot pipeline stage lines up with the ROM's 1-cycle read latency.
module startscreen_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ADDR_W   = 15,
  parameter int COLOR_W  = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [7:0]        X_LAST    = 8'(SCREEN_W - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ax_q, ax_d, px_q, px_d;
  logic [6:0]        ay_q, ay_d, py_q, py_d;
  logic              pv_q, pv_d;
  logic              done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    px_d    = px_q;
    py_d    = py_q;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_DRAW;
          addr_d  = '0;
          ax_d    = '0;
          ay_d    = '0;
        end
      end
      S_DRAW: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          px_d = ax_q;
          py_d = ay_q;
          pv_d = 1'b1;
          // Counters freeze on the last address so they never run past the frame.
          if (addr_q == LAST_ADDR) begin
            state_d = S_FLUSH;
          end else begin
            addr_d = addr_q + 1'b1;
            if (ax_q == X_LAST) begin
              ax_d = '0;
              ay_d = ay_q + 1'b1;
            end else begin
              ax_d = ax_q + 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        done_d  = !abort;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_address = (state_q == S_DRAW) ? addr_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign vga_x       = px_q;
  assign vga_y       = py_q;
  assign vga_plot    = pv_q;
  assign vga_colour  = rom_q;

endmodule

// File: tb/tb_startscreen_drawer.sv
// Directed bench for startscreen_drawer with a 1-cycle-latency ROM model (ROM[a] = a[8:0]).
module tb_startscreen_drawer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, vga_plot;
  logic [14:0] rom_address;
  logic [8:0]  rom_q = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;

  int checks = 0;
  int failures = 0;

  startscreen_drawer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_address(rom_address), .rom_q(rom_q),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= rom_address[8:0];

  typedef struct {
    int k;
    int x;
    int y;
    int col;
  } vec_t;

  vec_t tbl[6];
  int   cap_x[6], cap_y[6], cap_c[6];

  int r_nplots, r_ndone, r_first_c, r_done_c, r_gaps, r_bad;
  int r_busy0, r_ab_plot, r_ab_busy, r_done_bad;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // kind: 1 = extra start at plot 5000, 2 = abort at plot 7000, 3 = reset at plot 7000
  task automatic run_copy(input int kind);
    int inj_c;
    int last_c;
    int k;
    r_nplots = 0; r_ndone = 0; r_first_c = -1; r_done_c = -1;
    r_gaps = 0; r_bad = 0; r_busy0 = -1; r_ab_plot = -1; r_ab_busy = -1;
    r_done_bad = 0;
    inj_c = -1; last_c = -1;
    for (int i = 0; i < 6; i++) begin
      cap_x[i] = -1; cap_y[i] = -1; cap_c[i] = -1;
    end
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    for (int c = 0; c < 20000; c++) begin
      if (c == 0) r_busy0 = int'(busy);
      if (inj_c >= 0 && c == inj_c + 1) begin
        r_ab_plot = int'(vga_plot);
        r_ab_busy = int'(busy);
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      if (vga_plot) begin
        k = r_nplots;
        if (r_first_c < 0) r_first_c = c;
        else if (c != last_c + 1) r_gaps++;
        if (int'(vga_x) != k % 160 || int'(vga_y) != k / 160 || int'(vga_colour) != (k % 512))
          r_bad++;
        for (int i = 0; i < 6; i++)
          if (tbl[i].k == k) begin
            cap_x[i] = int'(vga_x); cap_y[i] = int'(vga_y); cap_c[i] = int'(vga_colour);
          end
        if (kind == 1 && k == 5000) start = 1'b1;
        if (kind == 2 && k == 7000) begin abort = 1'b1; inj_c = c; end
        if (kind == 3 && k == 7000) begin reset = 1'b1; inj_c = c; end
        last_c = c;
        r_nplots++;
      end
      if (done) begin
        r_ndone++;
        if (r_done_c < 0) r_done_c = c;
        if (busy || vga_plot) r_done_bad++;
      end
      if (r_done_c >= 0 && c >= r_done_c + 3) break;
      if (inj_c >= 0 && c >= inj_c + 5) break;
      @(negedge clock);
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int d1, d2, fp_c, fp_x, fp_y, kk, bad;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{159, 159, 0, 159};
    tbl[2] = '{160, 0, 1, 160};
    tbl[3] = '{319, 159, 1, 319};
    tbl[4] = '{5000, 40, 31, 392};
    tbl[5] = '{19199, 159, 119, 255};

    // Reset held 3 cycles with start high
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("rst%0d_busy", i), int'(busy), 0);
      check($sformatf("rst%0d_done", i), int'(done), 0);
      check($sformatf("rst%0d_plot", i), int'(vga_plot), 0);
      check($sformatf("rst%0d_addr", i), int'(rom_address), 0);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_plot", int'(vga_plot), 0);
    check("post_rst_addr", int'(rom_address), 0);

    // Full frame with an ignored start at plot 5000
    run_copy(1);
    check("f1_busy_after_start", r_busy0, 1);
    check("f1_first_plot_cycle", r_first_c, 1);
    check("f1_nplots", r_nplots, 19200);
    check("f1_gaps", r_gaps, 0);
    check("f1_bad_pixels", r_bad, 0);
    check("f1_done_cycle", r_done_c, 19201);
    check("f1_done_count", r_ndone, 1);
    check("f1_done_busy_plot_low", r_done_bad, 0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tbl_k%0d_x", tbl[i].k), cap_x[i], tbl[i].x);
      check($sformatf("tbl_k%0d_y", tbl[i].k), cap_y[i], tbl[i].y);
      check($sformatf("tbl_k%0d_col", tbl[i].k), cap_c[i], tbl[i].col);
    end

    // Abort mid-copy, then reset mid-copy on a fresh copy, then a copy after reset
    for (int kind = 2; kind <= 3; kind++) begin
      run_copy(kind);
      check($sformatf("ab%0d_first_plot_cycle", kind), r_first_c, 1);
      check($sformatf("ab%0d_bad_pixels", kind), r_bad, 0);
      check($sformatf("ab%0d_nplots", kind), r_nplots, 7001);
      check($sformatf("ab%0d_plot_after", kind), r_ab_plot, 0);
      check($sformatf("ab%0d_busy_after", kind), r_ab_busy, 0);
      check($sformatf("ab%0d_no_done", kind), r_ndone, 0);
    end
    run_copy(2);
    check("after_rst_first_plot_cycle", r_first_c, 1);
    check("after_rst_bad_pixels", r_bad, 0);

    // Back-to-back with start held high
    d1 = -1; d2 = -1; fp_c = -1; fp_x = -1; fp_y = -1; kk = 0; bad = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    for (int c = 0; c < 40000; c++) begin
      if (vga_plot) begin
        if (int'(vga_x) != kk % 160 || int'(vga_y) != kk / 160 || int'(vga_colour) != (kk % 512))
          bad++;
        if (d1 >= 0 && fp_c < 0) begin
          fp_c = c; fp_x = int'(vga_x); fp_y = int'(vga_y);
        end
        kk++;
      end
      if (done) begin
        kk = 0;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d2 >= 0) break;
      @(negedge clock);
    end
    start = 1'b0;
    check("b2b_first_done", d1, 19201);
    check("b2b_done_period", d2 - d1, 19202);
    check("b2b_replot_delay", fp_c - d1, 2);
    check("b2b_replot_x", fp_x, 0);
    check("b2b_replot_y", fp_y, 0);
    check("b2b_bad_pixels", bad, 0);
    repeat (3) @(negedge clock);
    check("b2b_idle_after_release", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
